combat_resolver: RTL
====================

# combat_resolver

Second-generation per-frame hit resolver for the two-player fighter. It sits between the two player controllers and the renderer/HUD. Each frame it tests every player's active attack hitbox against the opponent's hurtbox, selecting a light or heavy attack profile. It applies per-type damage, hitstun and knockback, enforces one hit per attack activation, tracks HP, and runs the round state (idle, fight, KO, winner).

## Interface
- POS_WIDTH, 10, width of unsigned position inputs
- HP_MAX, 100, HP loaded at round start
- HP_WIDTH, 8, HP register width (HP_MAX < 2^HP_WIDTH)
- HURT_W / HURT_H / HURT_OFFX / HURT_OFFY, 16 / 28 / -8 / -28, hurtbox size and offset from (x,y)
- L_W / L_H / L_FWD / L_UP, 20 / 12 / 16 / -16, light hitbox geometry
- L_DMG / L_STUN / L_KBX / L_KBY, 5 / 12 / 4 / -2, light damage, stun frames, knockback
- H_W / H_H / H_FWD / H_UP, 28 / 14 / 16 / -18, heavy hitbox geometry
- H_DMG / H_STUN / H_KBX / H_KBY, 15 / 24 / 8 / -4, heavy damage, stun frames, knockback
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- SCEN  in  1  frame-step enable; all state updates occur only on clk edges with SCEN=1
- round_start  in  1  begin or restart a round (sampled on SCEN)
- pN_x, pN_y  in  POS_WIDTH each  player N position, N=1,2
- pN_face_right  in  1  player N facing
- pN_atk_active  in  1  player N attack in damaging frames
- pN_atk_heavy  in  1  1 = heavy profile, 0 = light
- pN_hit_event  out  1  one-clk pulse: player N was hit this frame
- pN_hitstun_active  out  1  player N stunned
- pN_kb_dx, pN_kb_dy  out  signed 8 each  knockback applied to player N
- pN_hp  out  HP_WIDTH  player N HP
- round_over  out  1  state == KO
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

## Operation
- Round FSM: IDLE, FIGHT, KO. Reset enters IDLE. round_start moves IDLE or KO to FIGHT and reloads both HP to HP_MAX. It also clears stun, knockback, winner and armed flags. In FIGHT, round_start restarts the round identically. Hits are evaluated only in FIGHT.
- Geometry is signed at POS_WIDTH+2 bits, with positions zero-extended.
  - Hitbox x = x+FWD when facing right, otherwise x-(FWD+W). Hitbox y = y+UP.
  - Overlap uses strict inequalities, so boxes sharing only an edge do not hit.
- Armed flag per attacker:
  - Set on any SCEN frame with atk_active=0.
  - Cleared on the frame its attack lands.
  - A hit requires armed=1, atk_active=1, overlap, and target hitstun_active=0; a stunned target is invulnerable.
- On a hit:
  - Damage is saturating: hp <= (hp > DMG) ? hp-DMG : 0.
  - Target stun starts with the profile's STUN.
  - Target kb_dx = +KBX if the attacker faces right, else -KBX. kb_dy = KBY.
- Simultaneous hits in one frame (a trade) are both applied.
- Transition to KO when any HP reaches 0:
  - Winner is the player with nonzero HP.
  - If both reach 0 in the same frame, winner = 11.
  - In KO, stun counters keep running, and hits are ignored.

## Timing
- Reset values:
  - FSM = IDLE.
  - HP = HP_MAX.
  - hit_event, hitstun_active, kb and winner = 0.
  - round_over = 0.
  - Armed flags = 0.
- Latency:
  - Inputs are sampled on a SCEN edge.
  - hit_event, HP, stun, kb and FSM outputs update at that same edge, i.e. they are registered and visible the next clk.
  - hit_event is cleared on every other clk edge, so it is exactly one clk wide.
- Stun timing:
  - On the hit frame, hitstun_active <= 1 and cnt <= STUN-1.
  - On each later SCEN frame: if cnt == 0, deassert, else decrement. This gives exactly STUN frames of stun.
  - kb outputs hold while stunned and are zeroed on the edge hitstun deasserts.
- Counter width is clog2(max(L_STUN,H_STUN)+1).
- Reset mid-round aborts everything asynchronously and returns to IDLE.

## Test plan
- Light hit: FIGHT; p1 (100,200) facing right, light; p2 (120,200) -> p2_hit_event one clk; p2_hp 95; p2 stun for 12 SCEN frames; p2_kb = (+4,-2) during stun, then (0,0).
- Range split: p2 at (150,200) -> light gives no hit; heavy hits with hp 85, 24 stun frames, kb (+8,-4). Facing left with p2 at (50,200), heavy -> kb_dx -8.
- Hit-once: hold p1_atk_active high for 40 frames over p2 -> exactly one hit. Drop for one frame and reassert -> a second hit, only after stun ends.
- Trade and draw: both HP 5, both land light in the same frame -> both hit_event, both hp 0, round_over=1, winner=11.
- Saturating KO: p2_hp 10, heavy hit -> hp 0 (no wrap), winner=01. Further attacks are ignored. round_start -> FIGHT with both hp 100.
- Reset mid-stun: assert reset during p2 stun -> all outputs return to reset values immediately, and FSM = IDLE.

Source files
------------

// File: rtl/combat_resolver.sv
// Per-frame hit resolver for the two-player fighter: hitbox/hurtbox overlap,
// damage, hitstun, knockback, one hit per attack activation, and round state.
module combat_resolver #(
  parameter int POS_WIDTH = 10,
  parameter int HP_MAX    = 100,
  parameter int HP_WIDTH  = 8,
  parameter int HURT_W    = 16,
  parameter int HURT_H    = 28,
  parameter int HURT_OFFX = -8,
  parameter int HURT_OFFY = -28,
  parameter int L_W       = 20,
  parameter int L_H       = 12,
  parameter int L_FWD     = 16,
  parameter int L_UP      = -16,
  parameter int L_DMG     = 5,
  parameter int L_STUN    = 12,
  parameter int L_KBX     = 4,
  parameter int L_KBY     = -2,
  parameter int H_W       = 28,
  parameter int H_H       = 14,
  parameter int H_FWD     = 16,
  parameter int H_UP      = -18,
  parameter int H_DMG     = 15,
  parameter int H_STUN    = 24,
  parameter int H_KBX     = 8,
  parameter int H_KBY     = -4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCEN,
  input  logic                  round_start,
  input  logic [POS_WIDTH-1:0]  p1_x,
  input  logic [POS_WIDTH-1:0]  p1_y,
  input  logic                  p1_face_right,
  input  logic                  p1_atk_active,
  input  logic                  p1_atk_heavy,
  input  logic [POS_WIDTH-1:0]  p2_x,
  input  logic [POS_WIDTH-1:0]  p2_y,
  input  logic                  p2_face_right,
  input  logic                  p2_atk_active,
  input  logic                  p2_atk_heavy,
  output logic                  p1_hit_event,
  output logic                  p1_hitstun_active,
  output logic signed [7:0]     p1_kb_dx,
  output logic signed [7:0]     p1_kb_dy,
  output logic [HP_WIDTH-1:0]   p1_hp,
  output logic                  p2_hit_event,
  output logic                  p2_hitstun_active,
  output logic signed [7:0]     p2_kb_dx,
  output logic signed [7:0]     p2_kb_dy,
  output logic [HP_WIDTH-1:0]   p2_hp,
  output logic                  round_over,
  output logic [1:0]            winner
);

  localparam int GW       = POS_WIDTH + 2;
  localparam int STUN_MAX = (L_STUN > H_STUN) ? L_STUN : H_STUN;
  localparam int CW       = $clog2(STUN_MAX + 1);

  typedef logic signed [GW-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, FIGHT, KO} state_t;

  localparam logic [HP_WIDTH-1:0] HP_INIT   = HP_WIDTH'(HP_MAX);
  localparam logic [HP_WIDTH-1:0] L_DMG_V   = HP_WIDTH'(L_DMG);
  localparam logic [HP_WIDTH-1:0] H_DMG_V   = HP_WIDTH'(H_DMG);
  localparam logic [CW-1:0]       L_STUN_M1 = CW'(L_STUN - 1);
  localparam logic [CW-1:0]       H_STUN_M1 = CW'(H_STUN - 1);
  localparam logic signed [7:0]   L_KBX_R   = 8'(L_KBX);
  localparam logic signed [7:0]   L_KBX_L   = 8'(-L_KBX);
  localparam logic signed [7:0]   H_KBX_R   = 8'(H_KBX);
  localparam logic signed [7:0]   H_KBX_L   = 8'(-H_KBX);
  localparam logic signed [7:0]   L_KBY_V   = 8'(L_KBY);
  localparam logic signed [7:0]   H_KBY_V   = 8'(H_KBY);

  state_t          state, state_n;
  logic            armed1, armed2;
  logic            hit1, hit2;          // hit1: p1 lands on p2, hit2: p2 lands on p1
  logic            fight_eval;
  logic [CW-1:0]   p1_cnt, p2_cnt;
  logic [HP_WIDTH-1:0] hp1_n, hp2_n;
  logic signed [7:0]   kbx_to_p1, kbx_to_p2, kby_to_p1, kby_to_p2;

  function automatic coord_t ext(input logic [POS_WIDTH-1:0] v);
    return coord_t'({2'b00, v});
  endfunction

  // Strict inequalities: boxes that only share an edge do not overlap.
  function automatic logic hit_test(
    input logic [POS_WIDTH-1:0] ax,
    input logic [POS_WIDTH-1:0] ay,
    input logic                 face,
    input logic                 heavy,
    input logic [POS_WIDTH-1:0] tx,
    input logic [POS_WIDTH-1:0] ty
  );
    coord_t w, h, fwd, up, bx, by, hx, hy;
    w   = heavy ? coord_t'(H_W)   : coord_t'(L_W);
    h   = heavy ? coord_t'(H_H)   : coord_t'(L_H);
    fwd = heavy ? coord_t'(H_FWD) : coord_t'(L_FWD);
    up  = heavy ? coord_t'(H_UP)  : coord_t'(L_UP);
    bx  = face ? ext(ax) + fwd : ext(ax) - (fwd + w);
    by  = ext(ay) + up;
    hx  = ext(tx) + coord_t'(HURT_OFFX);
    hy  = ext(ty) + coord_t'(HURT_OFFY);
    return (bx < hx + coord_t'(HURT_W)) && (hx < bx + w) &&
           (by < hy + coord_t'(HURT_H)) && (hy < by + h);
  endfunction

  function automatic logic [HP_WIDTH-1:0] sat_sub(
    input logic [HP_WIDTH-1:0] hp,
    input logic [HP_WIDTH-1:0] d
  );
    return (hp > d) ? hp - d : '0;
  endfunction

  assign fight_eval = SCEN && (state == FIGHT) && !round_start;

  assign hit1 = fight_eval && armed1 && p1_atk_active && !p2_hitstun_active &&
                hit_test(p1_x, p1_y, p1_face_right, p1_atk_heavy, p2_x, p2_y);
  assign hit2 = fight_eval && armed2 && p2_atk_active && !p1_hitstun_active &&
                hit_test(p2_x, p2_y, p2_face_right, p2_atk_heavy, p1_x, p1_y);

  assign hp2_n = hit1 ? sat_sub(p2_hp, p1_atk_heavy ? H_DMG_V : L_DMG_V) : p2_hp;
  assign hp1_n = hit2 ? sat_sub(p1_hp, p2_atk_heavy ? H_DMG_V : L_DMG_V) : p1_hp;

  assign kbx_to_p2 = p1_atk_heavy ? (p1_face_right ? H_KBX_R : H_KBX_L)
                                  : (p1_face_right ? L_KBX_R : L_KBX_L);
  assign kbx_to_p1 = p2_atk_heavy ? (p2_face_right ? H_KBX_R : H_KBX_L)
                                  : (p2_face_right ? L_KBX_R : L_KBX_L);
  assign kby_to_p2 = p1_atk_heavy ? H_KBY_V : L_KBY_V;
  assign kby_to_p1 = p2_atk_heavy ? H_KBY_V : L_KBY_V;

  assign round_over = (state == KO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (SCEN && round_start) state_n = FIGHT;
      FIGHT:   if (fight_eval && (hp1_n == '0 || hp2_n == '0)) state_n = KO;
      KO:      if (SCEN && round_start) state_n = FIGHT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_hp             <= HP_INIT;
      p2_hp             <= HP_INIT;
      p1_hit_event      <= 1'b0;
      p2_hit_event      <= 1'b0;
      p1_hitstun_active <= 1'b0;
      p2_hitstun_active <= 1'b0;
      p1_cnt            <= '0;
      p2_cnt            <= '0;
      p1_kb_dx          <= '0;
      p1_kb_dy          <= '0;
      p2_kb_dx          <= '0;
      p2_kb_dy          <= '0;
      winner            <= '0;
      armed1            <= 1'b0;
      armed2            <= 1'b0;
    end else begin
      // Hits are already SCEN-qualified, so the pulse drops on the next clk.
      p1_hit_event <= hit2;
      p2_hit_event <= hit1;
      if (SCEN) begin
        if (round_start) begin
          p1_hp             <= HP_INIT;
          p2_hp             <= HP_INIT;
          p1_hitstun_active <= 1'b0;
          p2_hitstun_active <= 1'b0;
          p1_cnt            <= '0;
          p2_cnt            <= '0;
          p1_kb_dx          <= '0;
          p1_kb_dy          <= '0;
          p2_kb_dx          <= '0;
          p2_kb_dy          <= '0;
          winner            <= '0;
          armed1            <= 1'b0;
          armed2            <= 1'b0;
        end else begin
          p1_hp <= hp1_n;
          p2_hp <= hp2_n;
          if (state == FIGHT && state_n == KO)
            winner <= {(hp1_n == '0), (hp2_n == '0)};

          if (hit2) begin
            p1_hitstun_active <= 1'b1;
            p1_cnt            <= p2_atk_heavy ? H_STUN_M1 : L_STUN_M1;
            p1_kb_dx          <= kbx_to_p1;
            p1_kb_dy          <= kby_to_p1;
          end else if (p1_hitstun_active) begin
            if (p1_cnt == '0) begin
              p1_hitstun_active <= 1'b0;
              p1_kb_dx          <= '0;
              p1_kb_dy          <= '0;
            end else begin
              p1_cnt <= p1_cnt - 1'b1;
            end
          end

          if (hit1) begin
            p2_hitstun_active <= 1'b1;
            p2_cnt            <= p1_atk_heavy ? H_STUN_M1 : L_STUN_M1;
            p2_kb_dx          <= kbx_to_p2;
            p2_kb_dy          <= kby_to_p2;
          end else if (p2_hitstun_active) begin
            if (p2_cnt == '0) begin
              p2_hitstun_active <= 1'b0;
              p2_kb_dx          <= '0;
              p2_kb_dy          <= '0;
            end else begin
              p2_cnt <= p2_cnt - 1'b1;
            end
          end

          if (hit1)                armed1 <= 1'b0;
          else if (!p1_atk_active) armed1 <= 1'b1;
          if (hit2)                armed2 <= 1'b0;
          else if (!p2_atk_active) armed2 <= 1'b1;
        end
      end
    end
  end

endmodule
